exe_unit_mc: RTL and testbench
==============================

EXE_UNIT_MC -- requirements
Module: exe_unit_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand/result width (legal range >= 8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning PC/branch address width.
REQ-003 The block SHALL have parameter IMM_W, default 24, meaning signed branch immediate width (legal range < ADDR_W).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 in_valid  in  1  upstream presents an operation.
REQ-007 in_ready  out  1  block accepts the operation this cycle.
REQ-008 exec_cmd  in  4  opcode: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MUL 1010, MLA 1011; others are NOP (result 0, flags unchanged).
REQ-009 s_bit  in  1  operation updates status flags.
REQ-010 val_1, val_2, val_acc  in  DATA_W each  first operand, pre-shifted second operand, MLA accumuland.
REQ-011 pc_in  in  ADDR_W  PC of the operation.
REQ-012 signed_imm  in  IMM_W  branch offset, two's complement.
REQ-013 status_in  in  4  current flags {Z,C,N,V} as bits [3:0]; C is bit 2.
REQ-014 flush  in  1  kill in-flight and pending-output operation.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 out_valid  out  1  result outputs valid.
REQ-017 alu_res  out  DATA_W  result.
REQ-018 status_out  out  4  new flags, same bit order as status_in.
REQ-019 status_we  out  1  out_valid AND captured s_bit.
REQ-020 branch_addr  out  ADDR_W  pc_in + sign-extended signed_imm, captured at acceptance.
REQ-021 busy  out  1  state is MUL.

Function
REQ-022 States SHALL be IDLE, MUL; in_ready = rst AND state==IDLE AND (NOT out_valid OR out_ready) AND NOT flush.
REQ-023 Acceptance SHALL occur when in_valid AND in_ready; all inputs, including status_in, sampled only then.
REQ-024 Single-cycle ops SHALL present result with out_valid=1 exactly one cycle after acceptance; back-to-back acceptance SHALL sustain one op per cycle when out_ready=1.
REQ-025 MUL/MLA SHALL move IDLE->MUL, perform DATA_W iterative shift-add steps, return to IDLE with out_valid=1 DATA_W+1 cycles after acceptance; result = low DATA_W bits of val_1*val_2 (+val_acc for MLA).
REQ-026 ADD/ADC/SUB/SBC SHALL update N,Z,C,V: C = carry out (SUB/SBC: NOT borrow); ADC adds C; SBC computes val_1-val_2-NOT C; V = signed overflow.
REQ-027 Logical, move and multiply ops SHALL update N (result MSB), Z (result==0), and pass C,V from sampled status_in.
REQ-028 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; out_valid clears after the out_ready handshake unless a new result is loaded the same cycle.
REQ-029 flush SHALL, on the next edge, clear out_valid, force state IDLE, and discard any MUL partial result; flush takes priority over acceptance in the same cycle.
REQ-030 Arithmetic SHALL wrap modulo 2^DATA_W; branch_addr SHALL wrap modulo 2^ADDR_W.
REQ-031 When status_we=0, status_out SHALL still show computed flags; consumers gate on status_we.

Reset
REQ-032 While rst=0 on an edge: state IDLE, out_valid=0, busy=0, alu_res=0, status_out=0, branch_addr=0; in_ready=0 while rst=0.
REQ-033 Reset asserted mid-MUL SHALL abort the operation with no out_valid pulse afterward.

Verification
REQ-034 ADD 0x7FFFFFFF+0x00000001, s_bit=1 -> next cycle alu_res=0x80000000, N=1 V=1 C=0 Z=0, status_we=1.
REQ-035 SUB 5-5, s_bit=1 -> alu_res=0, Z=1 C=1 N=0 V=0; same op with s_bit=0 -> status_we=0.
REQ-036 MLA 3*4+5 -> busy=1, in_ready=0 for 32 cycles, alu_res=17 with out_valid at cycle 33 after acceptance.
REQ-037 Hold out_ready=0 three cycles with result pending -> outputs unchanged, in_ready=0; release -> in_ready=1 same cycle.
REQ-038 Flush at cycle 10 of MUL -> out_valid stays 0, busy=0 next cycle, in_ready=1 the following cycle.
REQ-039 pc_in=0x00000100, signed_imm=0xFFFFFC -> branch_addr=0x000000FC; reset mid-MUL -> all outputs 0, no out_valid.

Source files
------------

// File: rtl/exe_unit_mc.sv
// Multi-cycle execute unit: single-cycle ALU ops plus an iterative shift-add MUL/MLA.
// Latency: ALU ops 1 cycle, MUL/MLA DATA_W+1 cycles; one ALU op per cycle when the output drains.
// Backpressure: results hold until out_ready; in_ready drops while busy, stalled or flushing.
module exe_unit_mc #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exec_cmd,
    input  logic              s_bit,
    input  logic [DATA_W-1:0] val_1,
    input  logic [DATA_W-1:0] val_2,
    input  logic [DATA_W-1:0] val_acc,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [IMM_W-1:0]  signed_imm,
    input  logic [3:0]        status_in,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_res,
    output logic [3:0]        status_out,
    output logic              status_we,
    output logic [ADDR_W-1:0] branch_addr,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_MLA = 4'b1011;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t             state, state_nxt;
    logic               accept, mul_done, is_mul, is_nop;
    logic               c_new, v_new, s_q;
    logic [1:0]         cv_q;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W:0]    sum;
    logic [DATA_W-1:0]  res, mcand, mplier, acc, mul_add;
    logic [3:0]         alu_flags, mul_flags;
    logic [ADDR_W-1:0]  branch_nxt;

    assign in_ready  = rst && (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign busy      = (state == MUL);
    assign status_we = out_valid && s_q;

    assign branch_nxt = pc_in + {{(ADDR_W-IMM_W){signed_imm[IMM_W-1]}}, signed_imm};

    // Flags are {Z,C,N,V}; NOP leaves the sampled flags untouched.
    always_comb begin
        sum    = '0;
        res    = '0;
        c_new  = status_in[2];
        v_new  = status_in[0];
        is_mul = 1'b0;
        is_nop = 1'b0;
        case (exec_cmd)
            OP_MOV: res = val_2;
            OP_MVN: res = ~val_2;
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, val_1} + {1'b0, val_2}
                      + {{DATA_W{1'b0}}, (exec_cmd == OP_ADC) & status_in[2]};
                res   = sum[MSB:0];
                c_new = sum[DATA_W];
                v_new = (val_1[MSB] == val_2[MSB]) && (res[MSB] != val_1[MSB]);
            end
            OP_SUB, OP_SBC: begin
                // a + ~b + cin: cin=1 for SUB, cin=C for SBC; carry out is NOT borrow.
                sum   = {1'b0, val_1} + {1'b0, ~val_2}
                      + {{DATA_W{1'b0}}, (exec_cmd == OP_SUB) | status_in[2]};
                res   = sum[MSB:0];
                c_new = sum[DATA_W];
                v_new = (val_1[MSB] != val_2[MSB]) && (res[MSB] != val_1[MSB]);
            end
            OP_AND: res = val_1 & val_2;
            OP_ORR: res = val_1 | val_2;
            OP_EOR: res = val_1 ^ val_2;
            OP_MUL, OP_MLA: is_mul = 1'b1;
            default: is_nop = 1'b1;
        endcase
        alu_flags = is_nop ? status_in : {res == '0, c_new, res[MSB], v_new};
    end

    assign mul_add   = mplier[0] ? (acc + mcand) : acc;
    assign mul_flags = {mul_add == '0, cv_q[1], mul_add[MSB], cv_q[0]};

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_done  = 1'b0;
        if (state == IDLE) begin
            if (accept && is_mul) state_nxt = MUL;
        end else if (cnt == CNT_W'(DATA_W - 1)) begin
            mul_done  = 1'b1;
            state_nxt = IDLE;
        end
        if (flush) begin
            state_nxt = IDLE;
            mul_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            alu_res     <= '0;
            status_out  <= '0;
            branch_addr <= '0;
            s_q         <= 1'b0;
            cv_q        <= '0;
            cnt         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                s_q         <= s_bit;
                cv_q        <= {status_in[2], status_in[0]};
                branch_addr <= branch_nxt;
                if (is_mul) begin
                    mcand  <= val_1;
                    mplier <= val_2;
                    acc    <= (exec_cmd == OP_MLA) ? val_acc : '0;
                    cnt    <= '0;
                end else begin
                    out_valid  <= 1'b1;
                    alu_res    <= res;
                    status_out <= alu_flags;
                end
            end
            // One shift-add step per cycle; the final step lands straight in the output.
            if (state == MUL) begin
                acc    <= mul_add;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_done) begin
                    out_valid  <= 1'b1;
                    alu_res    <= mul_add;
                    status_out <= mul_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_exe_unit_mc.sv
// Randomized and directed bench for exe_unit_mc with a queue-based scoreboard.
module tb_exe_unit_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  exec_cmd = '0;
    logic        s_bit = 1'b0;
    logic [31:0] val_1 = '0, val_2 = '0, val_acc = '0, pc_in = '0;
    logic [23:0] signed_imm = '0;
    logic [3:0]  status_in = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] alu_res;
    logic [3:0]  status_out;
    logic        status_we;
    logic [31:0] branch_addr;
    logic        busy;

    exe_unit_mc #(.DATA_W(32), .ADDR_W(32), .IMM_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exec_cmd(exec_cmd), .s_bit(s_bit), .val_1(val_1), .val_2(val_2),
        .val_acc(val_acc), .pc_in(pc_in), .signed_imm(signed_imm),
        .status_in(status_in), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .alu_res(alu_res), .status_out(status_out),
        .status_we(status_we), .branch_addr(branch_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        we;
        logic [31:0] ba;
        int          due;
    } exp_t;

    exp_t  sbq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    or_mode = 0;   // 0: out_ready=1, 1: random, 2: driven by the sequence
    bit    seen = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain wide arithmetic on the architectural rules.
    function automatic exp_t model(input logic [3:0] cmd, input logic s,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ac, input logic [3:0] st,
                                   input logic [31:0] pc, input logic [23:0] imm);
        exp_t        e;
        logic [31:0] r;
        logic [63:0] u, bin;
        logic        c, v;
        longint      sr;
        bit          nop;
        r = '0; c = st[2]; v = st[0]; nop = 0; u = '0; bin = '0; sr = 0;
        case (cmd)
            4'h1: r = b;
            4'h9: r = ~b;
            4'h2, 4'h3: begin
                u  = 64'(a) + 64'(b) + ((cmd == 4'h3 && st[2]) ? 64'd1 : 64'd0);
                r  = u[31:0];
                c  = u[32];
                sr = longint'($signed(a)) + longint'($signed(b)) + ((cmd == 4'h3 && st[2]) ? 64'sd1 : 64'sd0);
                v  = (sr != longint'($signed(r)));
            end
            4'h4, 4'h5: begin
                bin = (cmd == 4'h5 && !st[2]) ? 64'd1 : 64'd0;
                c   = (64'(a) >= 64'(b) + bin);
                r   = a - b - bin[31:0];
                sr  = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
                v   = (sr != longint'($signed(r)));
            end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = a ^ b;
            4'hA, 4'hB: begin
                u = 64'(a) * 64'(b) + ((cmd == 4'hB) ? 64'(ac) : 64'd0);
                r = u[31:0];
            end
            default: nop = 1;
        endcase
        e.res = r;
        e.fl  = nop ? st : {r == 32'd0, c, r[31], v};
        e.we  = s;
        e.ba  = pc + 32'(int'($signed(imm)));
        e.due = 0;
        return e;
    endfunction

    // Presents one operation, waits (bounded) for acceptance, pushes the expectation.
    task automatic issue(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ac, input logic [3:0] st,
                         input logic [31:0] pc, input logic [23:0] imm);
        exp_t e;
        bit   ok = 0;
        in_valid = 1'b1; exec_cmd = cmd; s_bit = s; val_1 = a; val_2 = b;
        val_acc = ac; status_in = st; pc_in = pc; signed_imm = imm;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            e = model(cmd, s, a, b, ac, st, pc, imm);
            e.due = cyc + ((cmd == 4'hA || cmd == 4'hB) ? 33 : 1);
            sbq.push_back(e);
        end else begin
            check("accept_timeout", 128'(in_ready), 128'(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (or_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
        else if (or_mode == 0) out_ready = 1'b1;
    end

    // Monitor: latency on first appearance, contents on handshake, stability while stalled.
    logic [69:0] snap;
    bit          stall_prev = 0;
    always @(negedge clk) begin
        if (stall_prev && rst)
            check("hold_stable", 128'({out_valid, alu_res, status_out, status_we, branch_addr}), 128'(snap));
        stall_prev = rst && out_valid && !out_ready && !flush;
        snap = {out_valid, alu_res, status_out, status_we, branch_addr};
        if (rst && out_valid) begin
            if (sbq.size() == 0) begin
                if (out_ready) check("unexpected_output", 128'(out_valid), 128'(0));
            end else begin
                if (!seen) begin
                    check("latency", 128'(cyc), 128'(sbq[0].due));
                    seen = 1;
                end
                if (out_ready) begin
                    check("alu_res", 128'(alu_res), 128'(sbq[0].res));
                    check("status_out", 128'(status_out), 128'(sbq[0].fl));
                    check("status_we", 128'(status_we), 128'(sbq[0].we));
                    check("branch_addr", 128'(branch_addr), 128'(sbq[0].ba));
                    void'(sbq.pop_front());
                    seen = 0;
                end else begin
                    check("in_ready_stall", 128'(in_ready), 128'(0));
                end
            end
        end
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h7fff_ffff;
            2: return 32'h8000_0000;
            3: return 32'hffff_ffff;
            default: return $urandom;
        endcase
    endfunction

    int          busy_cnt, ov_cnt;
    bit          rdy_seen;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_outputs", 128'({alu_res, status_out, branch_addr}), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and idle gaps
        or_mode = 1;
        for (int n = 0; n < 250; n++) begin
            issue(4'($urandom_range(0, 15)), 1'($urandom), rnd_val(), rnd_val(), rnd_val(),
                  4'($urandom), $urandom, 24'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        or_mode = 0;
        @(posedge clk); #1;

        // Signed overflow on ADD
        issue(4'b0010, 1'b1, 32'h7fff_ffff, 32'h0000_0001, 32'd0, 4'b0000, 32'd0, 24'd0);
        check("add_ovf_res", 128'(alu_res), 128'(32'h8000_0000));
        check("add_ovf_flags", 128'({status_out, status_we}), 128'({4'b0011, 1'b1}));

        // SUB to zero, with and without flag update
        issue(4'b0100, 1'b1, 32'd5, 32'd5, 32'd0, 4'b0000, 32'd0, 24'd0);
        check("sub_zero", 128'({alu_res, status_out, status_we}), 128'({32'd0, 4'b1100, 1'b1}));
        issue(4'b0100, 1'b0, 32'd5, 32'd5, 32'd0, 4'b0000, 32'd0, 24'd0);
        check("sub_no_we", 128'({out_valid, status_we}), 128'({1'b1, 1'b0}));

        // MLA latency and busy window
        issue(4'b1011, 1'b0, 32'd3, 32'd4, 32'd5, 4'b0000, 32'd0, 24'd0);
        busy_cnt = 0; rdy_seen = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_seen = 1;
            @(posedge clk); #1;
        end
        check("mla_busy_cycles", 128'(busy_cnt), 128'(32));
        check("mla_in_ready_low", 128'(rdy_seen), 128'(0));
        check("mla_result", 128'({out_valid, alu_res}), 128'({1'b1, 32'd17}));
        @(posedge clk); #1;

        // Output held under backpressure, released in the same cycle
        or_mode = 2; out_ready = 1'b0;
        issue(4'b1000, 1'b1, 32'h0000_f0f0, 32'h0000_0ff0, 32'd0, 4'b0000, 32'd0, 24'd0);
        repeat (3) begin
            check("stall_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk); #1;
        end
        check("stall_held", 128'({out_valid, alu_res}), 128'({1'b1, 32'h0000_ff00}));
        out_ready = 1'b1; #1;
        check("release_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;

        // Flush kills a stalled result
        out_ready = 1'b0;
        issue(4'b0111, 1'b0, 32'h1, 32'h2, 32'd0, 4'b0000, 32'd0, 24'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; sbq.delete(); seen = 0;
        check("flush_pending", 128'(out_valid), 128'(0));
        or_mode = 0; out_ready = 1'b1;
        @(posedge clk); #1;

        // Flush at cycle 10 of a MUL
        issue(4'b1010, 1'b1, 32'd6, 32'd7, 32'd0, 4'b0000, 32'd0, 24'd0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; sbq.delete(); seen = 0;
        check("flush_mul_state", 128'({busy, out_valid}), 128'(0));
        @(posedge clk); #1;
        check("flush_mul_ready", 128'(in_ready), 128'(1));
        ov_cnt = 0;
        repeat (40) begin
            if (out_valid) ov_cnt++;
            @(posedge clk); #1;
        end
        check("flush_mul_no_out", 128'(ov_cnt), 128'(0));

        // Branch target with negative offset
        issue(4'b0001, 1'b0, 32'd0, 32'h0000_1234, 32'd0, 4'b0000, 32'h0000_0100, 24'hff_fffc);
        check("branch_neg", 128'(branch_addr), 128'(32'h0000_00fc));
        @(posedge clk); #1;

        // Reset in the middle of a MUL
        issue(4'b1010, 1'b1, 32'd7, 32'd9, 32'd0, 4'b0000, 32'h40, 24'h10);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mul_ctrl", 128'({out_valid, busy, in_ready}), 128'(0));
        check("rst_mul_data", 128'({alu_res, status_out, branch_addr}), 128'(0));
        rst = 1'b1; sbq.delete(); seen = 0;
        ov_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        check("rst_mul_no_out", 128'(ov_cnt), 128'(0));

        check("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
